ram_io_responder: RTL and testbench



---
 rtl/ram_io_responder_pkg.sv | 24 ++
 rtl/ram_io_responder_if.sv | 38 +++
 rtl/ram_io_responder_io_byte_fifo.sv | 72 +++++++
 rtl/ram_io_responder.sv | 101 ++++++++++
 tb/tb_ram_io_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared memory-bus definitions for the controller/responder pair: bus widths,
// IO window addresses and the read/write encoding the controller drives.
package ram_io_responder_pkg;

  localparam int MEM_DATA_W = 8;
  localparam int ADDR_BUS_W = 32;

  typedef logic [MEM_DATA_W-1:0] mem_data_bus_t;
  typedef logic [ADDR_BUS_W-1:0] addr_bus_t;

  localparam addr_bus_t IO_BASE = 32'h0003_0000;
  localparam addr_bus_t IO_HALT = 32'h0003_0004;

  // Must stay identical to the controller's mem_rw encoding.
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_rw_e;

  function automatic logic is_io(input addr_bus_t a);
    return a[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Memory bus between controller and responder, plus the host-side byte streams.
interface ram_io_responder_if #(
  parameter int TX_DEPTH = 16
);
  import ram_io_responder_pkg::*;

  logic          rdy_in;
  addr_bus_t     mem_a;
  logic          mem_rw;
  mem_data_bus_t mem_din;
  mem_data_bus_t mem_dout;
  logic          io_buffer_full;

  // tx: a byte moves to the host on every rising clk where tx_valid && tx_ready;
  // tx_data/tx_valid never depend on tx_ready. rx: rx_data is held while
  // rx_valid is high and is consumed by the single-cycle rx_pop pulse.
  mem_data_bus_t tx_data;
  logic          tx_valid;
  logic          tx_ready;
  mem_data_bus_t rx_data;
  logic          rx_valid;
  logic          rx_pop;

  logic          halt;
  logic          overflow;
  logic [$clog2(TX_DEPTH):0] tx_count;

  modport master (
    output rdy_in, mem_a, mem_rw, mem_din, tx_ready, rx_data, rx_valid,
    input  mem_dout, io_buffer_full, tx_data, tx_valid, rx_pop, halt, overflow, tx_count
  );

  modport slave (
    input  rdy_in, mem_a, mem_rw, mem_din, tx_ready, rx_data, rx_valid,
    output mem_dout, io_buffer_full, tx_data, tx_valid, rx_pop, halt, overflow, tx_count
  );

endinterface

// File: rtl/ram_io_responder_io_byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO is only accepted
// when a pop frees a slot in the same cycle, otherwise it is reported as dropped.
module io_byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  mem_data_bus_t           push_data,
  input  logic                    pop,
  output mem_data_bus_t           head,
  output logic                    empty,
  output logic                    dropped,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  count_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  mem_data_bus_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    dropped    = push && !do_push;
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: RAM array plus IO window (UART tx FIFO, rx byte,
// halt flag), with registered read data and registered backpressure.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 17,
  parameter string INIT_FILE   = "",
  parameter int    TX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 4
) (
  input logic                clk,
  input logic                rst,
  ram_io_responder_if.slave  bus
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_THRESH = CW'(TX_DEPTH - FULL_MARGIN);

  mem_data_bus_t ram [0:(1 << ADDR_WIDTH) - 1];

  logic            sel_io;
  logic            sel_tx;
  logic            sel_halt;
  logic            req_wr;
  logic            req_rd;
  logic [ADDR_WIDTH-1:0] ram_idx;
  mem_data_bus_t   rd_byte;

  mem_data_bus_t   fifo_head;
  logic            fifo_empty;
  logic            fifo_dropped;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   fifo_count_next;

  always_comb begin
    sel_io   = is_io(bus.mem_a);
    sel_tx   = (bus.mem_a == IO_BASE);
    sel_halt = (bus.mem_a == IO_HALT);
    req_wr   = bus.rdy_in && (bus.mem_rw == MEM_WRITE);
    req_rd   = bus.rdy_in && (bus.mem_rw == MEM_READ);
    ram_idx  = bus.mem_a[ADDR_WIDTH-1:0];
    rd_byte  = '0;
    if (!sel_io) begin
      rd_byte = ram[ram_idx];
    end else if (sel_tx) begin
      rd_byte = bus.rx_valid ? bus.rx_data : '0;
    end else if (sel_halt) begin
      rd_byte = {7'b0, !fifo_empty};
    end
  end

  // RAM is not cleared by reset, but a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && req_wr && !sel_io) begin
      ram[ram_idx] <= bus.mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_dout       <= '0;
      bus.rx_pop         <= 1'b0;
      bus.halt           <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.io_buffer_full <= 1'b0;
    end else begin
      if (bus.rdy_in) begin
        bus.mem_dout <= req_wr ? '0 : rd_byte;
      end
      bus.rx_pop <= req_rd && sel_tx && bus.rx_valid;
      if (req_wr && sel_halt) begin
        bus.halt <= 1'b1;
      end
      if (fifo_dropped) begin
        bus.overflow <= 1'b1;
      end
      // Headroom of FULL_MARGIN slots absorbs writes already in flight.
      bus.io_buffer_full <= (fifo_count_next >= FULL_THRESH);
    end
  end

  io_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (req_wr && sel_tx),
    .push_data  (bus.mem_din),
    .pop        (bus.tx_ready),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .dropped    (fifo_dropped),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_count = fifo_count;

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: vector table for RAM/IO decode, directed
// sequences for FIFO fill/overflow/drain, halt and mid-stream reset.
module tb_ram_io_responder;
  import ram_io_responder_pkg::*;

  localparam int TX_DEPTH    = 16;
  localparam int FULL_MARGIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_io_responder_if #(.TX_DEPTH(TX_DEPTH)) bus ();

  ram_io_responder #(
    .ADDR_WIDTH  (17),
    .INIT_FILE   (""),
    .TX_DEPTH    (TX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic       m_halt;
  logic       m_ovf;
  logic [7:0] last_dout;

  typedef struct {
    logic        rdy;
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  din;
    logic        rxv;
    logic [7:0]  rxd;
    logic [7:0]  exp_dout;
    logic        exp_pop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic rdy, input logic rw, input logic [31:0] addr,
                         input logic [7:0] din, input logic rxv, input logic [7:0] rxd,
                         input logic [7:0] exp_dout, input logic exp_pop);
    vec_t v;
    v.rdy = rdy; v.rw = rw; v.addr = addr; v.din = din;
    v.rxv = rxv; v.rxd = rxd; v.exp_dout = exp_dout; v.exp_pop = exp_pop;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rdy, input logic rw, input logic [31:0] addr,
                      input logic [7:0] din, input logic txr, input logic rxv,
                      input logic [7:0] rxd, input logic [7:0] exp_dout, input logic exp_pop);
    int  pre_size;
    bit  pop_now;
    logic [7:0] got;
    bus.rdy_in   = rdy;
    bus.mem_rw   = rw;
    bus.mem_a    = addr;
    bus.mem_din  = din;
    bus.tx_ready = txr;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    pre_size = tx_q.size();
    pop_now  = txr && (pre_size > 0);
    if (pop_now) begin
      check("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_q[0]});
      void'(tx_q.pop_front());
    end
    if (rdy && rw && addr == IO_BASE) begin
      if (pre_size < TX_DEPTH || pop_now) tx_q.push_back(din);
      else m_ovf = 1'b1;
    end
    if (rdy && rw && addr == IO_HALT) m_halt = 1'b1;
    exp_q.push_back(exp_dout);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("mem_dout", {24'b0, bus.mem_dout}, {24'b0, got});
    check("rx_pop", {31'b0, bus.rx_pop}, {31'b0, exp_pop});
    check("halt", {31'b0, bus.halt}, {31'b0, m_halt});
    check("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
    check("tx_count", 32'(bus.tx_count), 32'(tx_q.size()));
    check("tx_valid", {31'b0, bus.tx_valid}, {31'b0, tx_q.size() > 0});
    check("io_buffer_full", {31'b0, bus.io_buffer_full},
          {31'b0, tx_q.size() >= (TX_DEPTH - FULL_MARGIN)});
    last_dout = got;
  endtask

  // Reset with a write request present; it must be discarded.
  task automatic do_reset(input logic [31:0] addr, input logic [7:0] din);
    rst          = 1'b1;
    bus.rdy_in   = 1'b1;
    bus.mem_rw   = 1'b1;
    bus.mem_a    = addr;
    bus.mem_din  = din;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rdy_in   = 1'b0;
    bus.rx_valid = 1'b0;
    tx_q.delete();
    exp_q.delete();
    m_halt    = 1'b0;
    m_ovf     = 1'b0;
    last_dout = 8'h00;
    check("rst_mem_dout", {24'b0, bus.mem_dout}, 32'h0);
    check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("rst_tx_count", 32'(bus.tx_count), 32'h0);
    check("rst_io_buffer_full", {31'b0, bus.io_buffer_full}, 32'h0);
    check("rst_rx_pop", {31'b0, bus.rx_pop}, 32'h0);
    check("rst_halt", {31'b0, bus.halt}, 32'h0);
    check("rst_overflow", {31'b0, bus.overflow}, 32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    bus.rdy_in = 1'b0; bus.mem_rw = 1'b0; bus.mem_a = '0; bus.mem_din = '0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset(32'h0000_0200, 8'h33);

    // RAM preload of the boot image, reads, IO decode, rdy_in gating.
    add_vec(1, 1, 32'h0,       8'h13, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h1,       8'h05, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h2,       8'h00, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h3,       8'h00, 0, 8'h00, 8'h00, 0);
    add_vec(1, 0, 32'h0,       8'h00, 0, 8'h00, 8'h13, 0);
    add_vec(1, 0, 32'h1,       8'h00, 0, 8'h00, 8'h05, 0);
    add_vec(1, 0, 32'h2,       8'h00, 0, 8'h00, 8'h00, 0);
    add_vec(1, 0, 32'h3,       8'h00, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h100,     8'hAB, 0, 8'h00, 8'h00, 0);
    add_vec(1, 0, 32'h100,     8'h00, 0, 8'h00, 8'hAB, 0);
    add_vec(1, 1, 32'h200,     8'h77, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h1FFFF,   8'h5A, 0, 8'h00, 8'h00, 0);
    add_vec(1, 0, 32'h1FFFF,   8'h00, 0, 8'h00, 8'h5A, 0);
    add_vec(1, 0, IO_BASE,     8'h00, 1, 8'h41, 8'h41, 1);
    add_vec(1, 0, IO_BASE,     8'h00, 0, 8'h41, 8'h00, 0);
    add_vec(1, 0, IO_HALT,     8'h00, 0, 8'h00, 8'h00, 0);
    add_vec(1, 1, 32'h30008,   8'h99, 0, 8'h00, 8'h00, 0);
    add_vec(1, 0, 32'h30008,   8'h00, 1, 8'h42, 8'h00, 0);
    add_vec(1, 0, 32'h100,     8'h00, 0, 8'h00, 8'hAB, 0);
    add_vec(0, 1, 32'h200,     8'hEE, 0, 8'h00, 8'hAB, 0);
    add_vec(0, 0, IO_BASE,     8'h00, 1, 8'h55, 8'hAB, 0);
    add_vec(1, 0, 32'h200,     8'h00, 0, 8'h00, 8'h77, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rdy, vecs[i].rw, vecs[i].addr, vecs[i].din, 1'b0,
           vecs[i].rxv, vecs[i].rxd, vecs[i].exp_dout, vecs[i].exp_pop);
    end

    // Fill the FIFO with the host stalled; io_buffer_full follows the 12th push.
    for (int i = 0; i < TX_DEPTH; i++) begin
      step(1, 1, IO_BASE, 8'h10 + 8'(i), 0, 0, 8'h00, 8'h00, 0);
    end
    step(1, 0, IO_HALT, 8'h00, 0, 0, 8'h00, 8'h01, 0);
    // Push and pop together at full: accepted, no overflow.
    step(1, 1, IO_BASE, 8'hC0, 1, 0, 8'h00, 8'h00, 0);
    // Push into full FIFO with no pop: dropped, overflow set.
    step(1, 1, IO_BASE, 8'hEE, 0, 0, 8'h00, 8'h00, 0);
    // Drain with rdy_in low: host pops continue, mem_dout holds.
    for (int k = 0; k < 40 && (tx_q.size() > 0 || bus.tx_valid); k++) begin
      step(0, 0, 32'h0, 8'h00, 1, 0, 8'h00, last_dout, 0);
    end
    check("drain_done", {31'b0, bus.tx_valid}, 32'h0);

    // Halt is sticky; a reset mid-stream clears it, the FIFO and mem_dout.
    step(1, 1, IO_HALT, 8'h01, 0, 0, 8'h00, 8'h00, 0);
    step(1, 1, IO_BASE, 8'hAA, 0, 0, 8'h00, 8'h00, 0);
    step(1, 1, IO_BASE, 8'hBB, 0, 0, 8'h00, 8'h00, 0);
    step(1, 0, 32'h100, 8'h00, 0, 0, 8'h00, 8'hAB, 0);
    do_reset(32'h0000_0100, 8'h00);
    step(1, 0, 32'h100, 8'h00, 0, 0, 8'h00, 8'hAB, 0);
    step(1, 0, 32'h0,   8'h00, 0, 0, 8'h00, 8'h13, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule
